// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encoding, scoreboard entry
// layout, legacy boolean/load-info constants and the per-source RAW match helper.
package pipeline_hazard_ctrl_pkg;

  localparam logic       TRUE    = 1'b1;
  localparam logic       FALSE   = 1'b0;
  localparam logic [2:0] NOTLOAD = 3'd0;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    REDIR   = 2'd2,
    MWAIT   = 2'd3
  } state_e;

  typedef struct packed {
    logic       vld;
    logic [4:0] dst;
    logic       is_load;
  } sb_entry_t;

  // x0 is hard-wired zero, so a read of it can never depend on an in-flight writer.
  function automatic logic src_hit(sb_entry_t e, logic [4:0] rs, logic use_rs);
    return e.vld && use_rs && (rs != 5'd0) && (e.dst == rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: 3-entry EX/MEM/WB writer shift register plus RAW match against ID.
// Match bits are combinational from current entries; shift holds while advance=0.
module hazard_scoreboard
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  input  logic       ex_load_vld,
  input  logic [4:0] ex_load_dst,
  input  logic       ex_load_is_load,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic [2:0] match,
  output logic       ex_is_load
);

  // index 0 = EX, 1 = MEM, 2 = WB
  sb_entry_t [2:0] sb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb <= '0;
    end else if (advance) begin
      sb[2] <= sb[1];
      sb[1] <= sb[0];
      sb[0] <= '{vld: ex_load_vld, dst: ex_load_dst, is_load: ex_load_is_load};
    end
  end

  always_comb begin
    match = 3'b000;
    for (int i = 0; i < 3; i++) begin
      match[i] = id_valid && (src_hit(sb[i], id_rs1, id_use_rs1) ||
                              src_hit(sb[i], id_rs2, id_use_rs2));
    end
  end

  assign ex_is_load = sb[0].is_load;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: five-stage sequencer; stall/flush controls are same-cycle combinational.
// Define HAZARD_FORWARDING_EN to stall only on an EX-stage load (bypass covers the rest).
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_dst,
  input  logic             id_write_reg,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_if,
  output logic             flush_id,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_DEPTH - 1);

  state_e     mode;
  logic [1:0] flush_cnt;
  logic [2:0] sb_match;
  logic       ex_is_load;
  logic       raw;
  logic       unused_sb;

  // A flushed or stalled ID instruction becomes a bubble in EX.
  hazard_scoreboard u_sb (
    .clk             (clk),
    .rst_n           (rst_n),
    .advance         (~mem_busy),
    .ex_load_vld     (id_valid & id_write_reg & (id_dst != 5'd0) & ~flush_id),
    .ex_load_dst     (id_dst),
    .ex_load_is_load (id_is_load),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .match           (sb_match),
    .ex_is_load      (ex_is_load)
  );

`ifdef HAZARD_FORWARDING_EN
  assign raw       = sb_match[0] & ex_is_load;
  assign unused_sb = &{1'b0, sb_match[2:1]};
`else
  // WB is still checked: the register file has no write-through.
  assign raw       = |sb_match;
  assign unused_sb = ex_is_load;
`endif

  // Priority: mem wait, redirect (new or still counting), RAW stall.
  always_comb begin
    mode = RUN;
    if (rst_n) begin
      if (mem_busy)                             mode = MWAIT;
      else if (ex_redirect || flush_cnt != '0)  mode = REDIR;
      else if (raw)                             mode = LDSTALL;
    end
  end

  assign state     = mode;
  assign stall_if  = (mode == MWAIT) || (mode == LDSTALL);
  assign stall_id  = (mode == MWAIT) || (mode == LDSTALL);
  assign stall_ex  = (mode == MWAIT);
  assign stall_mem = (mode == MWAIT);
  assign flush_if  = (mode == REDIR);
  assign flush_id  = (mode == REDIR) || (mode == LDSTALL);

  // Counts the remaining flush cycles after the redirect cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (!mem_busy) begin
      if (ex_redirect)            flush_cnt <= FLUSH_RELOAD;
      else if (flush_cnt != '0)   flush_cnt <= flush_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        stall_cycles <= '0;
    else if (stall_if) stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule
